// File: rtl/gnrc_codec_pkg.sv
// Shared types and constants for the generic codec library blocks.
package gnrc_codec_pkg;

    // Rate meter control states; 2 bits wide to leave room for more states.
    typedef enum logic [1:0] {
        RM_IDLE = 2'd0,
        RM_MEAS = 2'd1
    } rate_meter_state_e;

    // Rate meter measurement modes as seen on mode_i.
    localparam logic RM_MODE_SINGLE   = 1'b0;
    localparam logic RM_MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/gnrc_sat_counter.sv
// Up-counter with synchronous clear and enable that holds at all-ones
// instead of wrapping.
module gnrc_sat_counter #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt;

    // Clear has priority over counting; the count never wraps past all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else if (en_i && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

    assign cnt_o = cnt;

endmodule

// File: rtl/gnrc_fractional_rate_meter.sv
// Counts pulse-active cycles over a window of (win+1) clocks and
// delivers the count on a valid/ready interface, single-shot or periodic.
module gnrc_fractional_rate_meter
    import gnrc_codec_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         mode_i,
    input  logic         ld_i,
    input  logic [N-1:0] win_i,
    input  logic         start_i,
    input  logic         clr_i,
    input  logic         pulse_i,
    output logic [N-1:0] res_o,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic         overrun_o,
    output logic         sat_o,
    output logic         busy_o
);

    rate_meter_state_e state_q;
    rate_meter_state_e state_d;

    logic [N-1:0] win_r;
    logic [N-1:0] wcnt;
    logic [N:0]   pcnt;
    logic [N:0]   sum;
    logic         abort;
    logic         meas;
    logic         end_win;
    logic         sat_hit;
    logic [N-1:0] res_next;

    // ld_i behaves as a clear plus window load, so both abort the same way.
    assign abort   = ld_i | clr_i;
    assign meas    = (state_q == RM_MEAS);
    assign end_win = meas && (wcnt == win_r) && !abort;

    // The final sample of the window is folded in on the closing edge.
    // pcnt is at most win_r there, so the sum fits in N+1 bits and its top
    // bit flags a count of exactly 2^N.
    assign sum      = pcnt + (N+1)'(pulse_i);
    assign sat_hit  = sum[N];
    assign res_next = sat_hit ? {N{1'b1}} : sum[N-1:0];

    // Pulse counter is held at zero outside MEAS and restarts every window.
    gnrc_sat_counter #(
        .W(N + 1)
    ) u_pcnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (abort | !meas | end_win),
        .en_i  (meas & pulse_i),
        .cnt_o (pcnt)
    );

    // Window position counter; restarts at each window boundary.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcnt <= '0;
        end else if (abort || !meas || end_win) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt + N'(1);
        end
    end

    // Window length register, only loaded by ld_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_r <= '0;
        end else if (ld_i) begin
            win_r <= win_i;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: abort wins, start only counts in IDLE, mode decides at window end.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = RM_IDLE;
        end else begin
            case (state_q)
                RM_IDLE: begin
                    if (start_i) begin
                        state_d = RM_MEAS;
                    end
                end
                RM_MEAS: begin
                    if (end_win && (mode_i == RM_MODE_SINGLE)) begin
                        state_d = RM_IDLE;
                    end
                end
                default: state_d = RM_IDLE;
            endcase
        end
    end

    // Result register and handshake flags; an unconsumed result that gets
    // replaced raises the sticky overrun, a same-edge consume does not.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_o       <= '0;
            res_valid_o <= 1'b0;
            overrun_o   <= 1'b0;
            sat_o       <= 1'b0;
        end else if (abort) begin
            res_valid_o <= 1'b0;
            overrun_o   <= 1'b0;
            sat_o       <= 1'b0;
        end else if (end_win) begin
            res_o       <= res_next;
            sat_o       <= sat_hit;
            res_valid_o <= 1'b1;
            if (res_valid_o && !res_ready_i) begin
                overrun_o <= 1'b1;
            end
        end else if (res_valid_o && res_ready_i) begin
            res_valid_o <= 1'b0;
        end
    end

    assign busy_o = meas;

endmodule

// File: doc/gnrc_fractional_rate_meter.md
Name: gnrc_fractional_rate_meter

Overview:
- Measures the density of a single-cycle pulse stream, such as the overflow output of the fractional counter or any strobe. It counts pulse-active cycles over a programmable window of (win+1) clocks.
- It recovers the numerator of a fractional rate: a stream of 5 pulses per 16 clocks measured over a 16-clock window yields 5.
- Sits beside the fractional divider in the generic codec library, for self-check, rate recovery and clock-ratio monitoring.
- Results are delivered on a valid/ready interface. The block supports single-shot or periodic back-to-back windows.

Parameters:
- N, default 8: width of the window length and the result; range >=1.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous assert, active-low.
- mode_i  input  1  0 = single window then idle; 1 = periodic back-to-back windows.
- ld_i  input  1  latch win_i; also acts as clr_i.
- win_i  input  N  window length minus 1.
- start_i  input  1  begin measurement; ignored unless IDLE.
- clr_i  input  1  synchronous abort; clears state and flags.
- pulse_i  input  1  sampled every MEAS cycle; counted when 1.
- res_o  output  N  pulse count of the last completed window.
- res_valid_o  output  1  res_o holds an unconsumed result.
- res_ready_i  input  1  consumer accepts res_o.
- overrun_o  output  1  sticky: an unconsumed result was overwritten.
- sat_o  output  1  last result saturated at 2^N-1.
- busy_o  output  1  state is MEAS.

Behaviour:
- Reset: state IDLE; win_r=0; all counters 0; res_o=0; res_valid_o=0; overrun_o=0; sat_o=0; busy_o=0.
- States:
  - IDLE: start_i -> MEAS; window counter wcnt=0, pulse count pcnt=0.
  - MEAS: each cycle, pcnt += pulse_i and wcnt++.
  - End of window when wcnt==win_r. On that edge:
    - res_o <= pcnt + pulse_i, saturated to 2^N-1; sat_o set if saturation occurred, else cleared.
    - res_valid_o <= 1.
    - mode_i=0 -> IDLE.
    - mode_i=1 -> stay in MEAS with wcnt=0, pcnt=0 (no gap cycle).
- Timing: start_i sampled at edge k -> pulse_i sampled at edges k+1 .. k+1+win_r. res_valid_o is high in the cycle after edge k+1+win_r.
- Window length: win_r=0 means a 1-clock window. win_r=2^N-1 means a 2^N-clock window; a count of 2^N saturates. The internal pcnt is N+1 bits wide.
- mode_i is sampled only at end of window.
- Handshake:
  - res_valid_o && res_ready_i: consume; res_valid_o <= 0 unless a new result lands on the same edge.
  - New result while res_valid_o=1 && res_ready_i=0: res_o is overwritten, res_valid_o stays 1, overrun_o <= 1 (sticky).
  - New result with a same-cycle consume: no overrun; res_valid_o stays 1 with the new data.
  - res_o is stable while res_valid_o=1, except on overrun overwrite.
- Priority: ld_i > clr_i > start_i/counting.
  - ld_i and clr_i: state IDLE; wcnt, pcnt, res_valid_o, overrun_o and sat_o all 0. res_o holds its last value.
  - ld_i additionally latches win_r <= win_i.
  - start_i on the same edge as ld_i or clr_i is ignored.
- start_i while in MEAS is ignored. win_i is not used except on ld_i.
- Reset mid-window: immediate return to the reset state; no partial result is produced.

Decomposition:
- Shared package gnrc_codec_pkg holds:
  - typedef enum logic [1:0] {RM_IDLE, RM_MEAS} rate_meter_state_e (2-bit, for expansion);
  - localparam RM_MODE_SINGLE=1'b0 and RM_MODE_PERIODIC=1'b1.
- Sub-module gnrc_sat_counter(N+1 bits internal, clear/enable/saturate) is natural for pcnt. The window counter is inline.

Test Plan:
- Pulse stream from a fractional counter (max=15, inc=5, periodic); win=15; mode=0; start -> one result res_o=5, sat_o=0, res_valid_o high 16 cycles after the start edge +1, then IDLE.
- win=7, mode=1, pulse_i held 1, res_ready_i=1 -> res_o=8 every 8 cycles with no gap; overrun_o stays 0; busy_o held 1.
- win=3, mode=1, pulse pattern 1,0,0,1 repeating, res_ready_i=0 -> first res_o=2; the second window overwrites it and overrun_o=1; then res_ready_i=1 for one cycle -> res_valid_o drops only if no new result lands on that edge.
- N=4, win=15, pulse_i=1 -> res_o=15, sat_o=1; next window with pulse_i=0 -> res_o=0, sat_o=0.
- clr_i asserted at window cycle 3 of win=9 with pulses present -> IDLE next cycle; res_valid_o=0; no result; start_i and ld_i on the same edge -> start ignored.
- rst_ni low mid-window for one cycle -> all outputs at reset values, win_r=0; a subsequent start gives a 1-clock window reporting pulse_i.
